// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: op classes, issue-FSM states, default latencies.
// Used by the issue controller and the MD unit itself.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTLO  = 4'd5,
        MD_MTHI  = 4'd6,
        MD_MFLO  = 4'd7,
        MD_MFHI  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2
    } md_state_e;

    localparam int MD_MUL_LAT = 5;
    localparam int MD_DIV_LAT = 10;
    localparam int MD_CNT_W   = 4;

    // Ops that are forwarded to the MD unit (everything except none/mfhi/mflo).
    function automatic logic md_is_issuable(input logic [3:0] op);
        return (op >= 4'(MD_MULT)) && (op <= 4'(MD_MTHI));
    endfunction

    // Ops that occupy the MD unit for a multi-cycle latency.
    function automatic logic md_is_start(input logic [3:0] op);
        return (op >= 4'(MD_MULT)) && (op <= 4'(MD_DIVU));
    endfunction

    function automatic logic md_is_mul(input logic [3:0] op);
        return (op == 4'(MD_MULT)) || (op == 4'(MD_MULTU));
    endfunction

endpackage

// File: rtl/md_lat_cnt.sv
// Down-counter for the MD busy window: load a latency, decrement to zero, flag zero.
module md_lat_cnt
    import md_pkg::*;
#(
    parameter int W = MD_CNT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    // Saturates at zero so a stray decrement never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// Issues MD ops from E exactly once, tracks the MD busy window and stalls D-stage
// MD instructions until HI/LO are ready; also muxes HI/LO for mfhi/mflo in E.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = MD_MUL_LAT,
    parameter int DIV_LAT = MD_DIV_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_uses_md,
    input  logic [3:0]  e_md_op,
    input  logic        e_hold,
    input  logic        md_busy,
    input  logic [31:0] md_lo,
    input  logic [31:0] md_hi,
    output logic [3:0]  md_op,
    output logic        stall_d,
    output logic [31:0] e_hilo
);

    localparam logic [MD_CNT_W-1:0] MUL_LD = MD_CNT_W'(MUL_LAT);
    localparam logic [MD_CNT_W-1:0] DIV_LD = MD_CNT_W'(DIV_LAT);

    md_state_e           state_q;
    logic                issued_q, issued_d;
    logic                cnt_load, cnt_dec, cnt_zero;
    logic [MD_CNT_W-1:0] cnt_ld_val, cnt;
    logic                busy_int;

    // An op held in E is forwarded only in its first E cycle.
    always_comb begin
        md_op    = 4'd0;
        if (md_is_issuable(e_md_op) && !issued_q)
            md_op = e_md_op;
        issued_d = e_hold && (issued_q || (md_op != 4'd0));
    end

    always_ff @(posedge clk) begin
        if (reset)
            issued_q <= 1'b0;
        else
            issued_q <= issued_d;
    end

    assign cnt_load   = (state_q == ST_IDLE) && md_is_start(md_op);
    assign cnt_ld_val = md_is_mul(md_op) ? MUL_LD : DIV_LD;
    assign cnt_dec    = (state_q != ST_IDLE);

    md_lat_cnt #(.W(MD_CNT_W)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_ld_val),
        .dec      (cnt_dec),
        .value    (cnt),
        .zero     (cnt_zero)
    );

    // Waiting states leave on the cycle the counter steps from 1 to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (md_is_mul(md_op))
                        state_q <= ST_MUL_WAIT;
                    else if (md_is_start(md_op))
                        state_q <= ST_DIV_WAIT;
                end
                ST_MUL_WAIT, ST_DIV_WAIT: begin
                    if ((cnt == MD_CNT_W'(1)) || cnt_zero)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The start term covers the issue cycle, before the FSM or md_busy reflect it.
    assign busy_int = (state_q != ST_IDLE) || md_is_start(md_op) || md_busy;
    assign stall_d  = d_uses_md && busy_int;

    always_comb begin
        case (e_md_op)
            4'(MD_MFLO): e_hilo = md_lo;
            4'(MD_MFHI): e_hilo = md_hi;
            default:     e_hilo = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized traffic against a cycle-count reference model.
module tb_md_issue_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset, d_uses_md, e_hold, md_busy;
    logic [3:0]  e_md_op;
    logic [31:0] md_lo, md_hi;
    logic [3:0]  md_op;
    logic        stall_d;
    logic [31:0] e_hilo;

    int n_pass = 0;
    int n_total = 0;

    md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .d_uses_md (d_uses_md),
        .e_md_op   (e_md_op),
        .e_hold    (e_hold),
        .md_busy   (md_busy),
        .md_lo     (md_lo),
        .md_hi     (md_hi),
        .md_op     (md_op),
        .stall_d   (stall_d),
        .e_hilo    (e_hilo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    // Reference model: the unit is busy through cycle busy_until; a new E
    // instruction is one whose previous cycle had e_hold low.
    int cyc = 0;
    int busy_until = -100;
    bit m_first = 1'b1;

    function automatic logic [3:0] m_op();
        if (e_md_op >= 4'd1 && e_md_op <= 4'd6 && m_first)
            return e_md_op;
        return 4'd0;
    endfunction

    function automatic bit m_state_busy();
        return cyc <= busy_until;
    endfunction

    always @(posedge clk) begin : model
        logic [3:0] o;
        o = m_op();
        if (reset) begin
            busy_until = -100;
            m_first = 1'b1;
        end else begin
            if (!m_state_busy()) begin
                if (o == 4'd1 || o == 4'd2)
                    busy_until = cyc + MUL_LAT;
                else if (o == 4'd3 || o == 4'd4)
                    busy_until = cyc + DIV_LAT;
            end
            m_first = !e_hold;
        end
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic d, input logic [3:0] op, input logic h,
                         input logic b, input logic [31:0] lo, input logic [31:0] hi);
        reset = r; d_uses_md = d; e_md_op = op; e_hold = h; md_busy = b;
        md_lo = lo; md_hi = hi;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string tag, input logic [3:0] eop, input logic est, input logic [31:0] ehl);
        chk({tag, " md_op"}, 32'(md_op), 32'(eop));
        chk({tag, " stall_d"}, 32'(stall_d), 32'(est));
        chk({tag, " e_hilo"}, e_hilo, ehl);
    endtask

    typedef struct {
        logic        d;
        logic [3:0]  op;
        logic        b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [3:0]  eop;
        logic        est;
        logic [31:0] ehl;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic d, input logic [3:0] op, input logic b, input logic [31:0] lo,
                       input logic [31:0] hi, input logic [3:0] eop, input logic est, input logic [31:0] ehl);
        vec_t v;
        v.d = d; v.op = op; v.b = b; v.lo = lo; v.hi = hi; v.eop = eop; v.est = est; v.ehl = ehl;
        vq.push_back(v);
    endtask

    initial begin
        logic [3:0] op, prev_op;
        logic       h, b, r, d, prev_h, prev_r;
        logic [3:0] eop;
        logic       est;
        logic [31:0] ehl, lo, hi;

        // Reset state
        drive(1, 1, 4'd0, 0, 0, 32'h55, 32'h66);
        tick();
        drive(1, 1, 4'd7, 0, 0, 32'h55, 32'h66);
        chk3("reset", 4'd0, 1'b0, 32'h55);
        tick();

        // MULT then mflo in D: 6 stall cycles, then product low word in E
        add(1, 4'd1, 0, 0, 0, 4'd1, 1, 0);
        for (int i = 0; i < MUL_LAT; i++) add(1, 4'd0, 0, 0, 0, 4'd0, 1, 0);
        add(1, 4'd0, 0, 0, 0, 4'd0, 0, 0);
        add(0, 4'd7, 0, 32'h0000_0c35, 32'h1, 4'd0, 0, 32'h0000_0c35);
        // MTLO while idle, mflo follows without stall
        add(1, 4'd5, 0, 0, 0, 4'd5, 0, 0);
        add(0, 4'd7, 0, 32'h1234, 0, 4'd0, 0, 32'h1234);
        add(0, 4'd6, 0, 0, 0, 4'd6, 0, 0);
        add(0, 4'd8, 0, 32'h1234, 32'hdead_beef, 4'd0, 0, 32'hdead_beef);
        // md_busy alone stalls an MD instruction in D
        add(1, 4'd0, 1, 0, 0, 4'd0, 1, 0);
        add(1, 4'd0, 0, 0, 0, 4'd0, 0, 0);
        add(0, 4'd0, 1, 0, 0, 4'd0, 0, 0);
        // DIVU 7/2 then mfhi: 11 stall cycles, remainder 1
        add(1, 4'd4, 0, 0, 0, 4'd4, 1, 0);
        for (int i = 0; i < DIV_LAT; i++) add(1, 4'd0, 0, 0, 0, 4'd0, 1, 0);
        add(1, 4'd0, 0, 0, 0, 4'd0, 0, 0);
        add(0, 4'd8, 0, 32'd3, 32'd1, 4'd0, 0, 32'd1);
        // Non-MD instruction in D through a DIV (divide by zero keeps full latency)
        add(0, 4'd3, 0, 0, 0, 4'd3, 0, 0);
        for (int i = 0; i < DIV_LAT; i++) add(0, 4'd0, 0, 0, 0, 4'd0, 0, 0);
        add(1, 4'd0, 0, 0, 0, 4'd0, 0, 0);

        foreach (vq[i]) begin
            drive(0, vq[i].d, vq[i].op, 0, vq[i].b, vq[i].lo, vq[i].hi);
            chk3($sformatf("vec%0d", i), vq[i].eop, vq[i].est, vq[i].ehl);
            tick();
        end

        // DIV then reset three cycles later: no residual stall
        drive(0, 1, 4'd3, 0, 0, 0, 0);
        chk3("divrst c0", 4'd3, 1, 0);
        tick();
        for (int i = 1; i < 3; i++) begin
            drive(0, 1, 4'd0, 0, 0, 0, 0);
            chk3($sformatf("divrst c%0d", i), 4'd0, 1, 0);
            tick();
        end
        drive(1, 1, 4'd0, 0, 0, 0, 0);
        chk3("divrst c3", 4'd0, 1, 0);
        tick();
        drive(0, 1, 4'd0, 0, 0, 0, 0);
        chk3("divrst after", 4'd0, 0, 0);
        tick();

        // MULT held in E for three cycles: single issue, count from first cycle
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 4'd1, (i < 2), 0, 0, 0);
            chk3($sformatf("hold c%0d", i), (i == 0) ? 4'd1 : 4'd0, 1, 0);
            tick();
        end
        for (int i = 3; i < 6; i++) begin
            drive(0, 1, 4'd0, 0, 0, 0, 0);
            chk3($sformatf("hold c%0d", i), 4'd0, 1, 0);
            tick();
        end
        drive(0, 1, 4'd0, 0, 0, 0, 0);
        chk3("hold c6", 4'd0, 0, 0);
        tick();
        drive(0, 0, 4'd5, 0, 0, 0, 0);
        chk3("hold next", 4'd5, 0, 0);
        tick();

        // Randomized traffic against the reference model
        prev_h = 1'b0; prev_r = 1'b0; prev_op = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            b = ($urandom_range(0, 7) == 0);
            d = $urandom_range(0, 1);
            h = ($urandom_range(0, 3) == 0);
            lo = $urandom; hi = $urandom;
            if (prev_h && !prev_r)
                op = prev_op;
            else if (m_state_busy() || b)
                op = (($urandom_range(0, 2) == 0) ? 4'd7 : 4'd0);
            else
                op = 4'($urandom_range(0, 8));
            drive(r, d, op, h, b, lo, hi);
            eop = m_op();
            est = d && (m_state_busy() || (eop >= 4'd1 && eop <= 4'd4) || b);
            ehl = (op == 4'd7) ? lo : (op == 4'd8) ? hi : 32'd0;
            chk3($sformatf("rnd%0d", i), eop, est, ehl);
            tick();
            prev_h = h; prev_r = r; prev_op = op;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
